// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with configurable frame format
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_BITS-1:0]          i_tx_data,
    input  logic                          i_tx_valid,
    output logic                          o_tx_ready,
    output logic                          o_tx_out,
    output logic                          o_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int          AW           = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] FULL_COUNT   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] COUNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [3:0]  DATA_LAST    = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST    = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;

    state_t               state;
    state_t               state_d;
    logic [15:0]          bit_cnt;
    logic [15:0]          bit_cnt_d;
    logic [3:0]           bit_idx;
    logic [3:0]           bit_idx_d;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_d;
    logic                 par_bit;
    logic                 par_bit_d;
    logic                 tx_d;
    logic                 tick;
    logic                 head_par;

    assign head         = mem[rd_ptr];
    assign o_tx_ready   = (count != FULL_COUNT);
    assign push         = i_tx_valid && o_tx_ready && !i_rst;
    assign o_fifo_count = count;
    assign o_tx_busy    = (state != S_IDLE) || (count != '0);
    assign tick         = (bit_cnt == BIT_LAST);
    // Parity is taken from the word as it is popped, before the shifter consumes it.
    assign head_par     = (PARITY == 2) ? ~(^head) : (^head);

    // Word storage; contents are don't-care after reset so no reset term here.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_tx_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Transmit FSM state, bit timing and the registered line output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            o_tx_out <= 1'b1;
        end else begin
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            bit_idx  <= bit_idx_d;
            shreg    <= shreg_d;
            par_bit  <= par_bit_d;
            o_tx_out <= tx_d;
        end
    end

    // Next-state logic: every bit boundary clears the period counter so frames never drift.
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt + 16'd1;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        par_bit_d = par_bit;
        pop       = 1'b0;
        tx_d      = 1'b1;

        case (state)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (count != '0) begin
                    pop       = 1'b1;
                    shreg_d   = head;
                    par_bit_d = head_par;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    shreg_d   = shreg >> 1;
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_idx_d = '0;
                        // Chain straight into the next start bit when a word is waiting.
                        if (count != '0) begin
                            pop       = 1'b1;
                            shreg_d   = head;
                            par_bit_d = head_par;
                            state_d   = S_START;
                        end else begin
                            state_d   = S_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx + 4'd1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench with a mid-bit sampling reference receiver
module tb_uart_tx_fifo;

    localparam int CPB = 217;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic [2:0] sel = 3'd0;
    int         cyc = 0;

    logic [4:0] v;
    logic [4:0] rdy;
    logic [4:0] txo;
    logic [4:0] bsy;
    logic [4:0] c0, c1, c2, c3;
    logic [2:0] c4;

    logic       line;
    logic       busy;
    logic       ready;
    logic [8:0] count_m;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign v[0] = tx_valid && (sel == 3'd0);
    assign v[1] = tx_valid && (sel == 3'd1);
    assign v[2] = tx_valid && (sel == 3'd2);
    assign v[3] = tx_valid && (sel == 3'd3);
    assign v[4] = tx_valid && (sel == 3'd4);

    uart_tx_fifo u_8n1 (
        .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data[7:0]), .i_tx_valid(v[0]),
        .o_tx_ready(rdy[0]), .o_tx_out(txo[0]), .o_tx_busy(bsy[0]), .o_fifo_count(c0));

    uart_tx_fifo #(.PARITY(1)) u_8e1 (
        .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data[7:0]), .i_tx_valid(v[1]),
        .o_tx_ready(rdy[1]), .o_tx_out(txo[1]), .o_tx_busy(bsy[1]), .o_fifo_count(c1));

    uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) u_8o2 (
        .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data[7:0]), .i_tx_valid(v[2]),
        .o_tx_ready(rdy[2]), .o_tx_out(txo[2]), .o_tx_busy(bsy[2]), .o_fifo_count(c2));

    uart_tx_fifo #(.DATA_BITS(5)) u_5n1 (
        .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data[4:0]), .i_tx_valid(v[3]),
        .o_tx_ready(rdy[3]), .o_tx_out(txo[3]), .o_tx_busy(bsy[3]), .o_fifo_count(c3));

    uart_tx_fifo #(.FIFO_DEPTH(4)) u_d4 (
        .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data[7:0]), .i_tx_valid(v[4]),
        .o_tx_ready(rdy[4]), .o_tx_out(txo[4]), .o_tx_busy(bsy[4]), .o_fifo_count(c4));

    always_comb begin
        line    = 1'b1;
        busy    = 1'b0;
        ready   = 1'b0;
        count_m = '0;
        case (sel)
            3'd0: begin line = txo[0]; busy = bsy[0]; ready = rdy[0]; count_m = {4'd0, c0}; end
            3'd1: begin line = txo[1]; busy = bsy[1]; ready = rdy[1]; count_m = {4'd0, c1}; end
            3'd2: begin line = txo[2]; busy = bsy[2]; ready = rdy[2]; count_m = {4'd0, c2}; end
            3'd3: begin line = txo[3]; busy = bsy[3]; ready = rdy[3]; count_m = {4'd0, c3}; end
            3'd4: begin line = txo[4]; busy = bsy[4]; ready = rdy[4]; count_m = {6'd0, c4}; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [8:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Reference receiver: finds the start edge (or takes a known start cycle) and samples each bit mid-period.
    task automatic rx_frame(input int nbits, input int npar, input int nstop,
                            input logic [8:0] exp_data, input logic exp_par,
                            input string tag, input int t_known, output int t_start);
        int         w;
        logic [8:0] got_d;
        w = 0;
        if (t_known >= 0) begin
            t_start = t_known;
            clocks(CPB / 2 - (cyc - t_known));
        end else begin
            while (line !== 1'b0 && w < 6000) begin
                @(negedge clk);
                w++;
            end
            if (line !== 1'b0) begin
                chk({tag, " start timeout"}, 32'(line), 32'd0);
                t_start = -1;
                return;
            end
            t_start = cyc;
            clocks(CPB / 2);
        end
        chk({tag, " start bit"}, 32'(line), 32'd0);
        got_d = '0;
        for (int i = 0; i < nbits; i++) begin
            clocks(CPB);
            got_d[i] = line;
        end
        chk({tag, " data"}, 32'(got_d), 32'(exp_data));
        if (npar != 0) begin
            clocks(CPB);
            chk({tag, " parity"}, 32'(line), 32'(exp_par));
        end
        for (int s = 0; s < nstop; s++) begin
            clocks(CPB);
            chk({tag, " stop"}, 32'(line), 32'd1);
        end
    endtask

    task automatic wait_idle(output int t_end);
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 20000) begin
            @(negedge clk);
            w++;
        end
        t_end = cyc;
        chk("busy release", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t_s, t_e, lat, t0, lows;
        int         starts[5];
        logic [8:0] words[6];
        words = '{9'h11, 9'h22, 9'h33, 9'h44, 9'h55, 9'h66};

        // Reset held with a valid request present: the request must be ignored.
        @(negedge clk);
        rst = 1'b1; sel = 3'd0; tx_data = 9'h0AA; tx_valid = 1'b1;
        clocks(3);
        tx_valid = 1'b0;
        rst = 1'b0;
        clocks(1);
        chk("reset line", 32'(line), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset count", 32'(count_m), 32'd0);
        chk("reset d4 ready", 32'(rdy[4]), 32'd1);

        // 8N1, 0x55
        sel = 3'd0;
        push_word(9'h055);
        lat = 1;
        while (line !== 1'b0 && lat < 3) begin
            @(negedge clk);
            lat++;
        end
        chk("8N1 start latency ok", 32'(lat <= 2), 32'd1);
        rx_frame(8, 0, 1, 9'h055, 1'b0, "8N1", cyc, t_s);
        wait_idle(t_e);
        chk("8N1 frame length", 32'(t_e - t_s), 32'd2170);
        chk("8N1 line idle", 32'(line), 32'd1);

        // 8E1, 0xA5 -> four ones, even parity 0
        sel = 3'd1;
        push_word(9'h0A5);
        rx_frame(8, 1, 1, 9'h0A5, 1'b0, "8E1", -1, t_s);
        wait_idle(t_e);
        chk("8E1 frame length", 32'(t_e - t_s), 32'd2387);

        // 8O2, 0x07 -> three ones, odd parity 0, two stop bits
        sel = 3'd2;
        push_word(9'h007);
        rx_frame(8, 1, 2, 9'h007, 1'b0, "8O2", -1, t_s);
        wait_idle(t_e);
        chk("8O2 frame length", 32'(t_e - t_s), 32'd2604);

        // 5N1, 0x1F
        sel = 3'd3;
        push_word(9'h01F);
        rx_frame(5, 0, 1, 9'h01F, 1'b0, "5N1", -1, t_s);
        wait_idle(t_e);
        chk("5N1 frame length", 32'(t_e - t_s), 32'd1519);

        // Depth 4: six pushes on consecutive clocks, sixth is refused
        sel = 3'd4;
        t0 = -1;
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = words[i];
            @(negedge clk);
            if (line === 1'b0 && t0 < 0) t0 = cyc;
            if (i == 4) begin
                chk("d4 full count", 32'(count_m), 32'd4);
                chk("d4 full ready", 32'(ready), 32'd0);
            end
        end
        tx_valid = 1'b0;
        chk("d4 count after drop", 32'(count_m), 32'd4);
        chk("d4 first frame started", 32'(t0 >= 0), 32'd1);
        for (int k = 0; k < 5; k++) begin
            rx_frame(8, 0, 1, words[k], 1'b0, "d4 frame", (k == 0) ? t0 : -1, starts[k]);
            if (k > 0) chk("d4 back-to-back spacing", 32'(starts[k] - starts[k-1]), 32'd2170);
        end
        wait_idle(t_e);
        chk("d4 last frame end", 32'(t_e - starts[4]), 32'd2170);
        lows = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (line !== 1'b1) lows++;
        end
        chk("d4 no sixth frame", 32'(lows), 32'd0);
        chk("d4 drained count", 32'(count_m), 32'd0);

        // Reset at clock 1000 of a frame with three words queued
        sel = 3'd0;
        t0 = -1;
        tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data = 9'(i + 1);
            @(negedge clk);
            if (line === 1'b0 && t0 < 0) t0 = cyc;
        end
        tx_valid = 1'b0;
        chk("rst frame started", 32'(t0 >= 0), 32'd1);
        while (cyc - t0 < 1000 && t0 >= 0) @(negedge clk);
        chk("rst queued count", 32'(count_m), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst abort line", 32'(line), 32'd1);
        chk("rst abort count", 32'(count_m), 32'd0);
        chk("rst abort ready", 32'(ready), 32'd1);
        chk("rst abort busy", 32'(busy), 32'd0);
        lows = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (line !== 1'b1) lows++;
        end
        chk("rst no further frames", 32'(lows), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_FREQ, default 25_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), range 2..65535.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-004 Parameter PARITY, default 0, 0 = none, 1 = even, 2 = odd.
REQ-005 Parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16, word buffer depth, power of two, 2..256.
REQ-007 i_clk  input  1  sole clock; all logic on rising edge.
REQ-008 i_rst  input  1  synchronous, active-high reset.
REQ-009 i_tx_data  input  DATA_BITS  word to enqueue.
REQ-010 i_tx_valid  input  1  enqueue request.
REQ-011 o_tx_ready  output  1  high when FIFO not full.
REQ-012 o_tx_out  output  1  serial line, idle high.
REQ-013 o_tx_busy  output  1  high while a frame is on the line or the FIFO holds a word.
REQ-014 o_fifo_count  output  clog2(FIFO_DEPTH)+1  words currently buffered.

Function
REQ-015 Push SHALL occur on any edge with i_tx_valid && o_tx_ready; a valid with o_tx_ready low SHALL be dropped silently, with no state change.
REQ-016 o_tx_ready SHALL be registered-equivalent to (o_fifo_count != FIFO_DEPTH) and reflect the count after the current edge.
REQ-017 Push and pop on the same edge: count unchanged; data SHALL be preserved FIFO-order; at full, push is still refused (ready was low).
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP; encoding free.
REQ-019 IDLE: o_tx_out = 1; if FIFO non-empty, pop head into shift register and enter START on the same edge.
REQ-020 Start bit (0) SHALL appear on o_tx_out within 2 clocks of the push edge when the FSM is IDLE and the FIFO is empty.
REQ-021 START: line 0 for exactly CLKS_PER_BIT clocks, then DATA.
REQ-022 DATA: DATA_BITS bits, LSB first, each exactly CLKS_PER_BIT clocks; then PARITY if PARITY != 0, else STOP.
REQ-023 PARITY: one bit for CLKS_PER_BIT clocks; even = XOR of data bits; odd = inverted XOR.
REQ-024 STOP: line 1 for exactly STOP_BITS*CLKS_PER_BIT clocks.
REQ-025 At end of STOP with FIFO non-empty, pop and enter START directly; the next start bit SHALL follow the last stop clock with zero idle clocks.
REQ-026 At end of STOP with FIFO empty, return to IDLE.
REQ-027 o_tx_busy SHALL be high in every non-IDLE state and whenever o_fifo_count != 0; low otherwise.
REQ-028 Bit-period counter SHALL be 16 bits and reset to 0 at every bit boundary; no cumulative drift: frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT clocks exactly.
REQ-029 o_tx_out SHALL be driven from a flop (glitch-free).
REQ-030 Inputs SHALL be ignored while i_rst is high.

Reset
REQ-031 On i_rst high at an edge: FSM = IDLE, o_tx_out = 1, o_tx_busy = 0, o_tx_ready = 1, o_fifo_count = 0, FIFO pointers and bit counters = 0.
REQ-032 Reset mid-frame SHALL abort the frame: o_tx_out is 1 on the clock after the reset edge, and buffered words are discarded.
REQ-033 FIFO storage contents need no reset.

Verification
REQ-034 Defaults (CLKS_PER_BIT = 217, 8N1): push 0x55 -> line 0,1,0,1,0,1,0,1,0,1 each 217 clocks, then high; busy drops after 2170 clocks total.
REQ-035 PARITY = 1, 8E1: push 0xA5 -> parity bit 0; PARITY = 2, STOP_BITS = 2: push 0x07 -> parity bit 0, stop high 434 clocks.
REQ-036 DATA_BITS = 5: push 0x1F -> exactly 5 data bits of 1, frame 7*217 clocks.
REQ-037 FIFO_DEPTH = 4: push 6 words on consecutive clocks -> first popped immediately, words 2-5 buffered, ready low, word 6 dropped; 5 frames transmitted back-to-back with no idle gap.
REQ-038 Assert i_rst at clock 1000 of a frame with 3 words queued -> line high next clock, count 0, ready 1, no further frames.
REQ-039 Bench SHALL check every frame against a bit-accurate reference receiver sampling at mid-bit.
